// File: rtl/icache.sv
// Direct-mapped instruction cache with one-word lines.
// Misses fill the line with four byte reads through a granted memory port.
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        start_fetch,
    input  logic [31:0] pc,
    output logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_addr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MISS = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]            state;
    logic [LINES-1:0]      line_vld;
    logic [TAG_W-1:0]      line_tag  [LINES];
    logic [31:0]           line_data [LINES];

    logic [29:0]           base;      // word address being filled
    logic [2:0]            acnt;      // addresses granted so far
    logic [1:0]            bcnt;      // bytes captured so far
    logic                  cap_pend;  // mem_din carries a byte this cycle
    logic                  flushed;
    logic [23:0]           fill;

    logic [INDEX_BITS-1:0] idx, fill_idx;
    logic [TAG_W-1:0]      tag, fill_tag;
    logic                  hit, issue, fill_done;
    logic [31:0]           fill_word;

    assign idx       = pc[INDEX_BITS+1:2];
    assign tag       = pc[31:INDEX_BITS+2];
    assign hit       = line_vld[idx] && (line_tag[idx] == tag);
    assign fill_idx  = base[INDEX_BITS-1:0];
    assign fill_tag  = base[29:INDEX_BITS];
    assign issue     = (state == S_MISS) && mem_grant && (acnt != 3'd4);
    assign fill_done = (state == S_MISS) && cap_pend && (bcnt == 2'd3);
    assign fill_word = {mem_din, fill};

    assign instr_ready = (state == S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            line_vld <= '0;
            instr    <= '0;
            instr_addr <= '0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            base     <= '0;
            acnt     <= '0;
            bcnt     <= '0;
            cap_pend <= 1'b0;
            flushed  <= 1'b0;
            fill     <= '0;
        end else if (rdy) begin
            case (state)
                S_IDLE: begin
                    if (rob_clear) begin
                        state <= S_HOLD;
                    end else if (start_fetch) begin
                        if (hit) begin
                            instr      <= line_data[idx];
                            instr_addr <= {pc[31:2], 2'b00};
                            state      <= S_RESP;
                        end else begin
                            base     <= pc[31:2];
                            mem_addr <= {pc[31:2], 2'b00};
                            mem_req  <= 1'b1;
                            acnt     <= '0;
                            bcnt     <= '0;
                            cap_pend <= 1'b0;
                            flushed  <= 1'b0;
                            state    <= S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (rob_clear)
                        flushed <= 1'b1;
                    cap_pend <= issue;
                    if (issue) begin
                        acnt <= acnt + 3'd1;
                        // Address stays on the last byte once all four are out
                        if (acnt != 3'd3)
                            mem_addr <= mem_addr + 32'd1;
                    end
                    if (cap_pend) begin
                        fill <= {mem_din, fill[23:8]};
                        bcnt <= bcnt + 2'd1;
                    end
                    if (fill_done) begin
                        line_vld[fill_idx] <= 1'b1;
                        mem_req            <= 1'b0;
                        if (flushed || rob_clear) begin
                            state <= S_HOLD;
                        end else begin
                            instr      <= fill_word;
                            instr_addr <= {base, 2'b00};
                            state      <= S_RESP;
                        end
                    end
                end
                S_RESP:  state <= S_HOLD;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays carry no reset; the valid bits gate them.
    always_ff @(posedge clk) begin
        if (rdy && fill_done) begin
            line_tag[fill_idx]  <= fill_tag;
            line_data[fill_idx] <= fill_word;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache against a line-level reference model.
module tb_icache;
    logic        clk = 1'b0;
    logic        rst, rdy, rob_clear, start_fetch, mem_grant;
    logic [31:0] pc;
    logic        instr_ready, mem_req;
    logic [31:0] instr, instr_addr, mem_addr;
    logic [7:0]  mem_din;

    int total = 0;
    int bad   = 0;

    logic [63:0] sbq[$];
    logic [31:0] gq[$];
    bit          rvalid [64];
    logic [23:0] rtag   [64];

    icache #(.INDEX_BITS(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
        .start_fetch(start_fetch), .pc(pc), .instr_ready(instr_ready),
        .instr(instr), .instr_addr(instr_addr), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_grant(mem_grant), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h00;
            32'h103: return 8'h00;
            default: begin
                h = a * 32'd2654435761;
                return h[23:16] ^ a[7:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    // Memory: returns the byte for the granted address on the next cycle
    always @(posedge clk) begin
        if (mem_req && mem_grant && rdy && !rst) begin
            mem_din <= mem_byte(mem_addr);
            gq.push_back(mem_addr);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && instr_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got instr %h addr %h expected no response", instr, instr_addr);
            end else begin
                e = sbq.pop_front();
                check("resp_instr", instr, e[63:32]);
                check("resp_addr", instr_addr, e[31:0]);
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input int gmode, input int flush_at,
                         input int stall_at, input int rst_at);
        logic [31:0] al;
        int          ix, given, cyc, pi;
        logic [23:0] tg;
        bit          hit, done, aborted, flushed, stalled, g;
        logic [31:0] a0;
        bit          pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        al  = {a[31:2], 2'b00};
        ix  = int'(al[7:2]);
        tg  = al[31:8];
        hit = rvalid[ix] && (rtag[ix] == tg);
        if (hit || (flush_at < 0 && rst_at < 0))
            sbq.push_back({mem_word(al), al});
        gq.delete();
        @(posedge clk); #1;
        start_fetch = 1'b1;
        pc = a;
        @(posedge clk); #1;
        start_fetch = 1'b0;
        pc = $urandom;
        @(negedge clk);
        if (hit) begin
            check("hit_ready", {31'd0, instr_ready}, 32'd1);
            check("hit_no_memreq", {31'd0, mem_req}, 32'd0);
        end else begin
            check("miss_memreq", {31'd0, mem_req}, 32'd1);
            given = 0; cyc = 0; pi = 0;
            done = 0; aborted = 0; flushed = 0; stalled = 0;
            while (!done && !aborted && cyc < 200) begin
                cyc++;
                @(posedge clk); #1;
                rob_clear = 1'b0;
                mem_grant = 1'b0;
                if (rst_at >= 0 && given == rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("rst_ready", {31'd0, instr_ready}, 32'd0);
                    check("rst_instr", instr, 32'd0);
                    check("rst_iaddr", instr_addr, 32'd0);
                    check("rst_memreq", {31'd0, mem_req}, 32'd0);
                    check("rst_memaddr", mem_addr, 32'd0);
                    for (int i = 0; i < 64; i++) rvalid[i] = 1'b0;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    aborted = 1;
                end else begin
                    if (stall_at >= 0 && given == stall_at && !stalled) begin
                        stalled = 1;
                        a0 = mem_addr;
                        repeat (3) begin
                            rdy = 1'b0;
                            @(negedge clk);
                            check("stall_memaddr", mem_addr, a0);
                            check("stall_memreq", {31'd0, mem_req}, 32'd1);
                            @(posedge clk); #1;
                        end
                        rdy = 1'b1;
                    end
                    if (flush_at >= 0 && given == flush_at && !flushed) begin
                        rob_clear = 1'b1;
                        flushed = 1;
                    end
                    g = (gmode == 0) ? 1'b1 : (gmode == 1) ? pat[pi % 6] : 1'($urandom_range(0, 1));
                    pi++;
                    if (given < 4 && g) begin
                        mem_grant = 1'b1;
                        given++;
                    end
                    @(negedge clk);
                    if (!mem_req) done = 1;
                end
            end
            mem_grant = 1'b0;
            rob_clear = 1'b0;
            if (!aborted) begin
                check("fill_done", {31'd0, done}, 32'd1);
                check("fill_addr_count", gq.size(), 32'd4);
                for (int k = 0; k < 4 && k < gq.size(); k++)
                    check("fill_addr", gq[k], al + k);
                rvalid[ix] = 1'b1;
                rtag[ix] = tg;
            end
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [31:0] pool [6] = '{32'h000, 32'h100, 32'h200, 32'h040, 32'h140, 32'h300};
        rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; start_fetch = 1'b0;
        mem_grant = 1'b0; pc = '0;
        for (int i = 0; i < 64; i++) rvalid[i] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'd0, instr_ready}, 32'd0);
        check("reset_instr", instr, 32'd0);
        check("reset_iaddr", instr_addr, 32'd0);
        check("reset_memreq", {31'd0, mem_req}, 32'd0);
        check("reset_memaddr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        fetch(32'h100, 0, -1, -1, -1);    // cold miss, word 0x00000513
        fetch(32'h100, 0, -1, -1, -1);    // hit
        fetch(32'h000, 0, -1, -1, -1);    // conflict pair
        fetch(32'h102, 0, -1, -1, -1);
        fetch(32'h000, 0, -1, -1, -1);
        fetch(32'h100, 1, -1, -1, -1);    // grant toggling
        fetch(32'h200, 0, 2, -1, -1);     // flushed fill
        fetch(32'h200, 0, -1, -1, -1);    // then hit
        fetch(32'h300, 1, -1, 2, -1);     // rdy stall
        fetch(32'h400, 0, -1, -1, 2);     // reset mid-miss
        fetch(32'h400, 2, -1, -1, -1);    // must miss again
        fetch(32'h400, 0, -1, -1, -1);

        for (int n = 0; n < 40; n++) begin
            fetch(pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)),
                  int'($urandom_range(0, 2)),
                  ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1,
                  -1, -1);
        end

        repeat (3) @(posedge clk);
        check("sb_drained", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
